dcpu_bus_ram: RTL and testbench
===============================

// Module: dcpu_bus_ram
// PURPOSE
//  Memory-side responder for the dcpu data/instruction bus (cs/we/addr/dat/ack).
//  Decodes an address window, serves reads and writes from an internal RAM,
//  inserts configurable wait states and returns a single-cycle ack with read data.
//  Sits between the dcpu bus and its program/data store; several instances with
//  different BASE_ADDR may share one bus.
// PARAMETERS
//  ADDR_BITS    12       RAM depth = 2**ADDR_BITS words of 16 bit
//  BASE_ADDR    16'h0000 window base; only bits [15:ADDR_BITS] are compared
//  WAIT_STATES  0        extra cycles between request accept and ack (0..15)
// PORTS
//  i_clk      in   1   clock, all state on rising edge
//  i_reset_n  in   1   reset, asynchronous, active-low
//  i_cs       in   1   bus request (chip select) from the initiator
//  i_we       in   1   1 = write, 0 = read; valid while i_cs high
//  i_addr     in   16  word address
//  i_dat      in   16  write data from the initiator
//  o_dat      out  16  read data, valid in the o_ack cycle
//  o_ack      out  1   transfer complete, exactly one cycle per transfer
//  i_wprot    in   1   write-protect enable (only with DCPU_RAM_WPROT_EN)
// BEHAVIOUR
//  - Reset (i_reset_n low, async): state IDLE, o_ack=0, o_dat=0, wait counter 0.
//    RAM contents are not cleared. Reset mid-transfer aborts it; no write commits.
//  - hit = i_cs && (i_addr[15:ADDR_BITS] == BASE_ADDR[15:ADDR_BITS]).
//  - States: IDLE, WAIT, ACK.
//    IDLE: on hit, latch addr offset, we, wdata; -> WAIT if WAIT_STATES>0
//          (counter loaded with WAIT_STATES-1), else -> ACK.
//    WAIT: if i_cs drops -> IDLE (abort, nothing written, no ack); else count
//          down; at 0 -> ACK.
//    ACK:  o_ack=1 for this cycle only; -> IDLE unconditionally. Bus inputs are
//          ignored in ACK (same request still on the bus).
//  - Commit point = edge entering ACK: write stores latched wdata to
//    mem[offset]; read loads o_dat <= mem[offset]. o_dat holds its value
//    otherwise (unchanged by writes).
//  - Latency: request sampled in cycle 0 -> o_ack in cycle 1+WAIT_STATES.
//    Back-to-back: i_cs held high across ack -> next request accepted in the
//    cycle after ACK (IDLE), i.e. one idle turnaround cycle per transfer.
//  - Miss (address outside window): no state change, o_ack stays 0.
//  - Address/we/data changes during WAIT are ignored (latched at accept).
//  - No wrap: offset is i_addr[ADDR_BITS-1:0]; window end is exact.
// CONFIGURATION
//  DCPU_RAM_WPROT_EN defined: adds port i_wprot and parameter WPROT_TOP
//    (default 16'h0100). A write with offset < WPROT_TOP while i_wprot was high
//    at accept is acked normally but not stored. Reads unaffected.
//  Not defined: no i_wprot port, no WPROT_TOP; all writes in window stored.
// TESTING
//  1 WAIT_STATES=0: write 0x1234 to 0x0010, then read 0x0010 -> ack 1 cycle
//    after each accept, o_dat=0x1234 in read ack cycle, ack width 1.
//  2 WAIT_STATES=3: read 0x0005 (preloaded 0xBEEF) -> o_ack in cycle 4,
//    o_dat=0xBEEF; addr changed to 0x0006 in cycle 2 has no effect.
//  3 WAIT_STATES=3: write 0x5555 to 0x0020, drop i_cs in cycle 2 -> no ack,
//    later read 0x0020 returns previous value 0x0000.
//  4 BASE_ADDR=16'h1000, ADDR_BITS=12: read 0x0FFF and 0x2000 -> no ack;
//    read 0x1FFF -> ack, data = mem[0xFFF].
//  5 Assert i_reset_n low during WAIT of a write -> o_ack=0, o_dat=0
//    immediately; after release, read shows write not committed.
//  6 DCPU_RAM_WPROT_EN, i_wprot=1: write 0xAAAA to 0x00FF -> acked, read
//    returns old value; write to 0x0100 -> stored; i_wprot=0 -> 0x00FF stored.

Source files
------------

// File: rtl/dcpu_bus_ram.sv
// dcpu_bus_ram: windowed RAM responder for the dcpu cs/we/addr/dat/ack bus with optional wait states.
// Optional feature macro: DCPU_RAM_WPROT_EN (adds i_wprot / WPROT_TOP write protection of the low region).
module dcpu_bus_ram #(
  parameter int unsigned ADDR_BITS   = 12,
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter int unsigned WAIT_STATES = 0
`ifdef DCPU_RAM_WPROT_EN
  ,
  parameter logic [15:0] WPROT_TOP   = 16'h0100
`endif
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_cs,
  input  logic        i_we,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_dat,
  output logic [15:0] o_dat,
  output logic        o_ack
`ifdef DCPU_RAM_WPROT_EN
  ,
  input  logic        i_wprot
`endif
);

  localparam int unsigned DEPTH     = 2 ** ADDR_BITS;
  localparam logic [3:0]  WS_LOAD_C = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam bit          NO_WAIT_C = (WAIT_STATES == 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  state_e               state_r;
  state_e               state_nxt_s;
  logic [3:0]           cnt_r;
  logic [3:0]           cnt_nxt_s;
  logic [ADDR_BITS-1:0] off_r;
  logic                 we_r;
  logic [15:0]          wdat_r;
  logic                 ack_r;
  logic [15:0]          dat_r;
  logic [15:0]          mem_r [DEPTH];

  logic                 hit_s;
  logic                 accept_s;
  logic                 commit_s;
  logic                 blocked_s;
  logic                 mem_wr_s;
  logic [ADDR_BITS-1:0] cmt_off_s;
  logic                 cmt_we_s;
  logic [15:0]          cmt_wdat_s;

  assign hit_s = i_cs && (i_addr[15:ADDR_BITS] == BASE_ADDR[15:ADDR_BITS]);

  // With no wait states the commit happens on the accept edge, so take the request straight off the bus
  assign cmt_off_s  = (state_r == ST_IDLE) ? i_addr[ADDR_BITS-1:0] : off_r;
  assign cmt_we_s   = (state_r == ST_IDLE) ? i_we : we_r;
  assign cmt_wdat_s = (state_r == ST_IDLE) ? i_dat : wdat_r;

`ifdef DCPU_RAM_WPROT_EN
  logic wprot_r;
  logic cmt_wprot_s;

  assign cmt_wprot_s = (state_r == ST_IDLE) ? i_wprot : wprot_r;
  assign blocked_s   = cmt_wprot_s && ({{(16-ADDR_BITS){1'b0}}, cmt_off_s} < WPROT_TOP);

  // protect flag captured at accept, like the rest of the request
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wprot_r <= 1'b0;
    end else if (accept_s) begin
      wprot_r <= i_wprot;
    end
  end
`else
  assign blocked_s = 1'b0;
`endif

  assign mem_wr_s = i_reset_n && commit_s && cmt_we_s && !blocked_s;

  // next-state, wait countdown and commit decode
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    accept_s    = 1'b0;
    commit_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (hit_s) begin
          accept_s = 1'b1;
          if (NO_WAIT_C) begin
            state_nxt_s = ST_ACK;
            commit_s    = 1'b1;
          end else begin
            state_nxt_s = ST_WAIT;
            cnt_nxt_s   = WS_LOAD_C;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!i_cs) begin
          state_nxt_s = ST_IDLE;
        end else if (cnt_r == 4'd0) begin
          state_nxt_s = ST_ACK;
          commit_s    = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      ST_ACK: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // control state, request latch and registered bus outputs
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      off_r   <= {ADDR_BITS{1'b0}};
      we_r    <= 1'b0;
      wdat_r  <= 16'h0000;
      ack_r   <= 1'b0;
      dat_r   <= 16'h0000;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      ack_r   <= commit_s;
      if (accept_s) begin
        off_r  <= i_addr[ADDR_BITS-1:0];
        we_r   <= i_we;
        wdat_r <= i_dat;
      end
      if (commit_s && !cmt_we_s) begin
        dat_r <= mem_r[cmt_off_s];
      end
    end
  end

  // storage array: deliberately not reset so contents survive a bus reset
  always_ff @(posedge i_clk) begin
    if (mem_wr_s) begin
      mem_r[cmt_off_s] <= cmt_wdat_s;
    end
  end

  assign o_ack = ack_r;
  assign o_dat = dat_r;

endmodule

// File: tb/tb_dcpu_bus_ram.sv
// Bench for dcpu_bus_ram: two responders share one bus (0x0000 window, no waits; 0x1000 window, 3 waits).
// A transaction-level model predicts ack/data every cycle; directed tests pin literal values.
module tb_dcpu_bus_ram;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs    = 1'b0;
  logic        we    = 1'b0;
  logic [15:0] addr  = 16'h0000;
  logic [15:0] wdat  = 16'h0000;
`ifdef DCPU_RAM_WPROT_EN
  logic        wprot = 1'b0;
`endif
  logic [15:0] lo_dat, hi_dat;
  logic        lo_ack, hi_ack;

  int          checks = 0;
  int          passed = 0;
  int          which_v, lat_v, acks;
  logic [15:0] rd_v;

  always #5 clk = ~clk;

  dcpu_bus_ram #(.ADDR_BITS(12), .BASE_ADDR(16'h0000), .WAIT_STATES(0)) u_lo (
    .i_clk(clk), .i_reset_n(rst_n), .i_cs(cs), .i_we(we), .i_addr(addr), .i_dat(wdat),
    .o_dat(lo_dat), .o_ack(lo_ack)
`ifdef DCPU_RAM_WPROT_EN
    , .i_wprot(wprot)
`endif
  );

  dcpu_bus_ram #(.ADDR_BITS(12), .BASE_ADDR(16'h1000), .WAIT_STATES(3)) u_hi (
    .i_clk(clk), .i_reset_n(rst_n), .i_cs(cs), .i_we(we), .i_addr(addr), .i_dat(wdat),
    .o_dat(hi_dat), .o_ack(hi_ack)
`ifdef DCPU_RAM_WPROT_EN
    , .i_wprot(wprot)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---- transaction model: index 0 = low window, 1 = high window ----
  logic [15:0] mem_m     [2][4096];
  bit          known_m   [2][4096];
  bit          pend_m    [2] = '{1'b0, 1'b0};
  int          acc_m     [2] = '{0, 0};
  logic [15:0] la_m      [2];
  logic [15:0] ld_m      [2];
  bit          lw_m      [2];
  bit          lp_m      [2];
  bit          exp_ack   [2] = '{1'b0, 1'b0};
  logic [15:0] exp_dat   [2] = '{16'h0000, 16'h0000};
  bit          dat_known [2] = '{1'b1, 1'b1};
  int          cyc = 0;

  function automatic int ws_of(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  function automatic logic [3:0] base_of(input int i);
    return (i == 0) ? 4'h0 : 4'h1;
  endfunction

  task automatic commit_m(input int i);
    bit blocked;
    blocked = lp_m[i] && (la_m[i][11:0] < 12'h100);
    exp_ack[i] = 1'b1;
    if (lw_m[i]) begin
      if (!blocked) begin
        mem_m[i][la_m[i][11:0]]   = ld_m[i];
        known_m[i][la_m[i][11:0]] = 1'b1;
      end
    end else begin
      exp_dat[i]   = mem_m[i][la_m[i][11:0]];
      dat_known[i] = known_m[i][la_m[i][11:0]];
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        pend_m[i] = 1'b0; exp_ack[i] = 1'b0; exp_dat[i] = 16'h0000; dat_known[i] = 1'b1;
      end
    end else begin
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (exp_ack[i]) begin
          exp_ack[i] = 1'b0;
        end else if (pend_m[i]) begin
          if (!cs) pend_m[i] = 1'b0;
          else if (cyc - acc_m[i] == ws_of(i)) begin
            pend_m[i] = 1'b0;
            commit_m(i);
          end
        end else if (cs && addr[15:12] == base_of(i)) begin
          la_m[i] = addr; lw_m[i] = we; ld_m[i] = wdat; acc_m[i] = cyc;
`ifdef DCPU_RAM_WPROT_EN
          lp_m[i] = wprot;
`else
          lp_m[i] = 1'b0;
`endif
          if (ws_of(i) == 0) commit_m(i);
          else pend_m[i] = 1'b1;
        end
      end
    end
  end

  // per-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    chk("lo_ack", {31'b0, lo_ack}, {31'b0, exp_ack[0]});
    chk("hi_ack", {31'b0, hi_ack}, {31'b0, exp_ack[1]});
    if (dat_known[0]) chk("lo_dat", {16'h0, lo_dat}, {16'h0, exp_dat[0]});
    if (dat_known[1]) chk("hi_dat", {16'h0, hi_dat}, {16'h0, exp_dat[1]});
  end

  // ---- stimulus helpers (called #1 after a rising edge) ----
  task automatic xfer(input logic [15:0] a, input logic w, input logic [15:0] d, input int budget,
                      output int which, output int lat, output logic [15:0] rd);
    which = 0; lat = 0; rd = 16'h0000;
    cs = 1'b1; we = w; addr = a; wdat = d;
    for (int k = 1; k <= budget && which == 0; k++) begin
      @(posedge clk); #1;
      if (lo_ack) begin which = 1; lat = k; rd = lo_dat; end
      else if (hi_ack) begin which = 2; lat = k; rd = hi_dat; end
    end
    cs = 1'b0;
    @(posedge clk); #1;
    if (which != 0) chk("ack_width", {30'b0, lo_ack, hi_ack}, 32'h0);
  endtask

  task automatic wr(input string tag, input logic [15:0] a, input logic [15:0] d, input int ew, input int el);
    xfer(a, 1'b1, d, 8, which_v, lat_v, rd_v);
    chk({tag, "_who"}, which_v, ew);
    chk({tag, "_lat"}, lat_v, el);
  endtask

  task automatic rdc(input string tag, input logic [15:0] a, input logic [15:0] ed, input int ew, input int el);
    xfer(a, 1'b0, 16'h0000, 8, which_v, lat_v, rd_v);
    chk({tag, "_who"}, which_v, ew);
    chk({tag, "_lat"}, lat_v, el);
    chk({tag, "_dat"}, {16'h0, rd_v}, {16'h0, ed});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected bench to finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_lo_ack", {31'b0, lo_ack}, 32'h0);
    chk("rst_hi_ack", {31'b0, hi_ack}, 32'h0);
    chk("rst_lo_dat", {16'h0, lo_dat}, 32'h0);
    chk("rst_hi_dat", {16'h0, hi_dat}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // no wait states: write then read back
    wr ("t1_wr", 16'h0010, 16'h1234, 1, 1);
    rdc("t1_rd", 16'h0010, 16'h1234, 1, 1);

    // request held across ack: one turnaround cycle between transfers
    cs = 1'b1; we = 1'b0; addr = 16'h0010; acks = 0;
    repeat (4) begin @(posedge clk); #1; if (lo_ack) acks++; end
    cs = 1'b0;
    chk("b2b_acks", acks, 2);
    @(posedge clk); #1;

    // three wait states; address change mid-wait is ignored
    wr("t2_pre0", 16'h1005, 16'hBEEF, 2, 4);
    wr("t2_pre1", 16'h1006, 16'h1111, 2, 4);
    cs = 1'b1; we = 1'b0; addr = 16'h1005;
    @(posedge clk); #1; chk("t2_c1", {31'b0, hi_ack}, 32'h0);
    @(posedge clk); #1; addr = 16'h1006;
    @(posedge clk); #1; chk("t2_c3", {31'b0, hi_ack}, 32'h0);
    @(posedge clk); #1;
    chk("t2_ack", {31'b0, hi_ack}, 32'h1);
    chk("t2_dat", {16'h0, hi_dat}, {16'h0, 16'hBEEF});
    cs = 1'b0;
    @(posedge clk); #1;

    // abort during wait: nothing written, no ack
    wr("t3_pre", 16'h1020, 16'h0000, 2, 4);
    cs = 1'b1; we = 1'b1; addr = 16'h1020; wdat = 16'h5555;
    @(posedge clk); #1;
    @(posedge clk); #1; cs = 1'b0;
    acks = 0;
    repeat (6) begin @(posedge clk); #1; if (hi_ack) acks++; end
    chk("t3_noack", acks, 0);
    rdc("t3_rd", 16'h1020, 16'h0000, 2, 4);

    // window edges
    wr ("t4_wlo", 16'h0FFF, 16'h0F0F, 1, 1);
    wr ("t4_whi", 16'h1FFF, 16'h7E57, 2, 4);
    rdc("t4_rlo", 16'h0FFF, 16'h0F0F, 1, 1);
    xfer(16'h2000, 1'b0, 16'h0000, 6, which_v, lat_v, rd_v);
    chk("t4_miss", which_v, 0);
    rdc("t4_rhi", 16'h1FFF, 16'h7E57, 2, 4);

    // async reset mid-write
    wr("t5_pre", 16'h1030, 16'h0A0A, 2, 4);
    chk("t5_hold", {16'h0, hi_dat}, {16'h0, 16'h7E57});
    cs = 1'b1; we = 1'b1; addr = 16'h1030; wdat = 16'hDEAD;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t5_ack",   {31'b0, hi_ack}, 32'h0);
    chk("t5_dat",   {16'h0, hi_dat}, 32'h0);
    chk("t5_lodat", {16'h0, lo_dat}, 32'h0);
    cs = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rdc("t5_rd",   16'h1030, 16'h0A0A, 2, 4);
    rdc("t5_keep", 16'h0010, 16'h1234, 1, 1);

`ifdef DCPU_RAM_WPROT_EN
    // write protection of the low region
    wprot = 1'b0; wr("t6_pre", 16'h00FF, 16'h1111, 1, 1);
    wprot = 1'b1; wr("t6_blk", 16'h00FF, 16'hAAAA, 1, 1);
    rdc("t6_rblk", 16'h00FF, 16'h1111, 1, 1);
    wr ("t6_top",  16'h0100, 16'h2222, 1, 1);
    rdc("t6_rtop", 16'h0100, 16'h2222, 1, 1);
    wprot = 1'b0; wr("t6_off", 16'h00FF, 16'hAAAA, 1, 1);
    rdc("t6_roff", 16'h00FF, 16'hAAAA, 1, 1);
`endif

    repeat (2) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
